// File: rtl/mips_pkg.sv
// Shared types and constants for the ALU operand stage: state encoding,
// ALU opcodes, the hard-wired zero register and a register-match helper.
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alucont_t;

  // True when src names the same non-zero register that dst will write.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side, ALU-side and pipeline-feedback signals of the operand stage.
// master = surrounding pipeline, slave = the operand stage itself.
interface alu_operand_stage_if
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rd;
  logic             in_uses_rt;
  logic [WIDTH-1:0] in_rs_val;
  logic [WIDTH-1:0] in_rt_val;
  logic [WIDTH-1:0] in_imm;
  logic             in_alusrc;
  logic [2:0]       in_alucont;
  logic             in_regwrite;
  logic             in_memtoreg;

  logic             exm_regwrite;
  logic [4:0]       exm_rd;
  logic [WIDTH-1:0] exm_result;
  logic             wb_regwrite;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_result;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cont;
  logic [WIDTH-1:0] out_store_data;
  logic [4:0]       out_rd;
  logic             out_regwrite;
  logic             out_memtoreg;
  logic [15:0]      stall_count;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_uses_rt, in_rs_val, in_rt_val, in_imm,
           in_alusrc, in_alucont, in_regwrite, in_memtoreg,
           exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_result, flush,
           out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_cont, out_store_data, out_rd,
           out_regwrite, out_memtoreg, stall_count
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_uses_rt, in_rs_val, in_rt_val, in_imm,
           in_alusrc, in_alucont, in_regwrite, in_memtoreg,
           exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_result, flush,
           out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_cont, out_store_data, out_rd,
           out_regwrite, out_memtoreg, stall_count
  );

endinterface

// File: rtl/fwd_mux.sv
// Forwarding selector for one source operand; EX/MEM beats MEM/WB, r0 never
// forwarded. Built only with macro ALU_FWD_EN, otherwise passes held value.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [4:0]       src,
  input  logic [WIDTH-1:0] held_val,
  input  logic             exm_regwrite,
  input  logic [4:0]       exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] fwd_val
);

`ifdef ALU_FWD_EN
  always_comb begin
    fwd_val = held_val;
    if (exm_regwrite && reg_hit(src, exm_rd)) begin
      fwd_val = exm_result;
    end else if (wb_regwrite && reg_hit(src, wb_rd)) begin
      fwd_val = wb_result;
    end
  end
`else
  logic unused_fb;
  assign unused_fb = ^{src, exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_result};
  assign fwd_val   = held_val;
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// One-entry operand buffer between decode and the ALU with hazard stalls,
// operand forwarding (macro ALU_FWD_EN) and a saturating stall counter.
module alu_operand_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input logic clk,
  input logic reset_n,
  alu_operand_stage_if.slave bus
);

  state_t           state_reg;
  logic [4:0]       rs_reg;
  logic [4:0]       rt_reg;
  logic [4:0]       rd_reg;
  logic [WIDTH-1:0] rs_val_reg;
  logic [WIDTH-1:0] rt_val_reg;
  logic [WIDTH-1:0] imm_reg;
  logic             alusrc_reg;
  logic [2:0]       alucont_reg;
  logic             regwrite_reg;
  logic             memtoreg_reg;
  logic [15:0]      stall_count_reg;

  logic             full;
  logic             hazard;
  logic             capture;
  logic [4:0]       src_num [2];
  logic [WIDTH-1:0] src_held[2];
  logic [WIDTH-1:0] src_fwd [2];

  assign full = (state_reg == FULL);

`ifdef ALU_FWD_EN
  // Only a load in the held slot cannot be covered by forwarding.
  assign hazard = full && memtoreg_reg && (rd_reg != REG_ZERO) &&
                  ((bus.in_rs == rd_reg) || (bus.in_uses_rt && (bus.in_rt == rd_reg)));
`else
  logic rs_pend;
  logic rt_pend;
  // Without forwarding, wait for any writer ahead of MEM/WB to retire.
  assign rs_pend = (full && regwrite_reg && reg_hit(bus.in_rs, rd_reg)) ||
                   (bus.exm_regwrite && reg_hit(bus.in_rs, bus.exm_rd));
  assign rt_pend = (full && regwrite_reg && reg_hit(bus.in_rt, rd_reg)) ||
                   (bus.exm_regwrite && reg_hit(bus.in_rt, bus.exm_rd));
  assign hazard  = rs_pend || (bus.in_uses_rt && rt_pend);
`endif

  assign bus.in_ready = reset_n && !hazard && (!full || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= EMPTY;
      rs_reg          <= '0;
      rt_reg          <= '0;
      rd_reg          <= '0;
      rs_val_reg      <= '0;
      rt_val_reg      <= '0;
      imm_reg         <= '0;
      alusrc_reg      <= 1'b0;
      alucont_reg     <= '0;
      regwrite_reg    <= 1'b0;
      memtoreg_reg    <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      if (bus.flush) begin
        state_reg <= EMPTY;
      end else if (capture) begin
        state_reg <= FULL;
      end else if (full && bus.out_ready) begin
        state_reg <= EMPTY;
      end

      if (capture) begin
        rs_reg       <= bus.in_rs;
        rt_reg       <= bus.in_rt;
        rd_reg       <= bus.in_rd;
        rs_val_reg   <= bus.in_rs_val;
        rt_val_reg   <= bus.in_rt_val;
        imm_reg      <= bus.in_imm;
        alusrc_reg   <= bus.in_alusrc;
        alucont_reg  <= bus.in_alucont;
        regwrite_reg <= bus.in_regwrite;
        memtoreg_reg <= bus.in_memtoreg;
      end

      if (bus.in_valid && hazard && !bus.flush && (stall_count_reg != 16'hFFFF)) begin
        stall_count_reg <= stall_count_reg + 16'd1;
      end
    end
  end

  assign src_num[0]  = rs_reg;
  assign src_held[0] = rs_val_reg;
  assign src_num[1]  = rt_reg;
  assign src_held[1] = rt_val_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_mux #(.WIDTH(WIDTH)) u_fwd (
        .src          (src_num[gi]),
        .held_val     (src_held[gi]),
        .exm_regwrite (bus.exm_regwrite),
        .exm_rd       (bus.exm_rd),
        .exm_result   (bus.exm_result),
        .wb_regwrite  (bus.wb_regwrite),
        .wb_rd        (bus.wb_rd),
        .wb_result    (bus.wb_result),
        .fwd_val      (src_fwd[gi])
      );
    end
  endgenerate

  assign bus.out_valid      = full;
  assign bus.alu_a          = src_fwd[0];
  assign bus.out_store_data = src_fwd[1];
  assign bus.alu_b          = alusrc_reg ? imm_reg : src_fwd[1];
  assign bus.alu_cont       = alucont_reg;
  assign bus.out_rd         = rd_reg;
  assign bus.out_regwrite   = regwrite_reg;
  assign bus.out_memtoreg   = memtoreg_reg;
  assign bus.stall_count    = stall_count_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.WIDTH(32)) bus ();

  alu_operand_stage #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_in(input logic vld, input logic [4:0] rs, input logic [31:0] rs_val,
                        input logic [4:0] rt, input logic [31:0] rt_val, input logic uses_rt,
                        input logic [31:0] imm, input logic alusrc, input logic [2:0] cont,
                        input logic [4:0] rd, input logic regwrite, input logic memtoreg);
    bus.in_valid    = vld;
    bus.in_rs       = rs;
    bus.in_rs_val   = rs_val;
    bus.in_rt       = rt;
    bus.in_rt_val   = rt_val;
    bus.in_uses_rt  = uses_rt;
    bus.in_imm      = imm;
    bus.in_alusrc   = alusrc;
    bus.in_alucont  = cont;
    bus.in_rd       = rd;
    bus.in_regwrite = regwrite;
    bus.in_memtoreg = memtoreg;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    bus.exm_regwrite = 1'b0;
    bus.exm_rd       = 5'd0;
    bus.exm_result   = 32'd0;
    bus.wb_regwrite  = 1'b0;
    bus.wb_rd        = 5'd0;
    bus.wb_result    = 32'd0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst in_ready", bus.in_ready, 1'b0);
    chk("rst alu_a", bus.alu_a, 32'd0);
    chk("rst alu_b", bus.alu_b, 32'd0);
    chk("rst out_rd", bus.out_rd, 5'd0);
    chk("rst stall_count", bus.stall_count, 16'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Directed vectors: inputs applied for one cycle, expected outputs seen in that cycle.
  typedef struct {
    logic        vld;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val, imm;
    logic        alusrc;
    logic [2:0]  cont;
    logic        rdy_out;
    logic        e_ovalid, e_iready;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_cont;
  } vec_t;

  vec_t vecs[4];

  // Reference model: one held transaction plus a full flag.
  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val, imm;
    logic        alusrc, regwrite, memtoreg;
    logic [2:0]  cont;
  } ent_t;

  ent_t        m;
  bit          m_full;
  logic [15:0] m_stall;

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] held);
`ifdef ALU_FWD_EN
    if (r != 0 && bus.exm_regwrite && bus.exm_rd == r) return bus.exm_result;
    if (r != 0 && bus.wb_regwrite && bus.wb_rd == r) return bus.wb_result;
`endif
    return held;
  endfunction

  function automatic logic pending(input logic [4:0] r);
    if (r == 0) return 1'b0;
    return (m_full && m.regwrite && m.rd == r) || (bus.exm_regwrite && bus.exm_rd == r);
  endfunction

  function automatic logic ref_hazard();
`ifdef ALU_FWD_EN
    return m_full && m.memtoreg && m.rd != 0 &&
           (bus.in_rs == m.rd || (bus.in_uses_rt && bus.in_rt == m.rd));
`else
    return pending(bus.in_rs) || (bus.in_uses_rt && pending(bus.in_rt));
`endif
  endfunction

  initial begin
    logic        exp_rdy;
    logic        hz;
    logic [31:0] exp_b;
    logic [31:0] fwd_exp;
    int          ntx;

    vecs[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 3'b010, 1'b1,
                1'b0, 1'b1, 32'd0, 32'd0, 3'b000};
    vecs[1] = '{1'b1, 5'd5, 5'd6, 5'd7, 32'd100, 32'd9, 32'h20, 1'b1, 3'b110, 1'b1,
                1'b1, 1'b1, 32'd5, 32'd7, 3'b010};
    vecs[2] = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b1,
                1'b1, 1'b1, 32'd100, 32'h20, 3'b110};
    vecs[3] = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b1,
                1'b0, 1'b1, 32'd100, 32'h20, 3'b110};

    // Vector table: basic transfer, immediate select, drain, hold after drain.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(vecs[i].vld, vecs[i].rs, vecs[i].rs_val, vecs[i].rt, vecs[i].rt_val, 1'b1,
             vecs[i].imm, vecs[i].alusrc, vecs[i].cont, vecs[i].rd, 1'b1, 1'b0);
      bus.out_ready = vecs[i].rdy_out;
      settle();
      $display("vec %0d: out_valid=%0b in_ready=%0b alu_a=0x%0h alu_b=0x%0h",
               i, bus.out_valid, bus.in_ready, bus.alu_a, bus.alu_b);
      chk($sformatf("vec%0d out_valid", i), bus.out_valid, vecs[i].e_ovalid);
      chk($sformatf("vec%0d in_ready", i), bus.in_ready, vecs[i].e_iready);
      chk($sformatf("vec%0d alu_a", i), bus.alu_a, vecs[i].e_a);
      chk($sformatf("vec%0d alu_b", i), bus.alu_b, vecs[i].e_b);
      chk($sformatf("vec%0d alu_cont", i), bus.alu_cont, vecs[i].e_cont);
      tick();
    end

    // Load-use: one stall cycle, one bubble, then the dependent op issues.
    do_reset();
    bus.out_ready = 1'b1;
    set_in(1'b1, 5'd1, 32'h40, 5'd0, 32'd0, 1'b0, 32'd8, 1'b1, 3'b010, 5'd4, 1'b1, 1'b1);
    settle();
    chk("lu lw accepted", bus.in_ready, 1'b1);
    tick();
    set_in(1'b1, 5'd4, 32'd1, 5'd5, 32'd2, 1'b1, 32'd0, 1'b0, 3'b010, 5'd8, 1'b1, 1'b0);
    settle();
    chk("lu stall in_ready", bus.in_ready, 1'b0);
    chk("lu lw out_memtoreg", bus.out_memtoreg, 1'b1);
    tick();
    settle();
    chk("lu bubble out_valid", bus.out_valid, 1'b0);
    chk("lu after in_ready", bus.in_ready, 1'b1);
    chk("lu stall_count", bus.stall_count, 16'd1);
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("lu add out_valid", bus.out_valid, 1'b1);
    chk("lu add out_rd", bus.out_rd, 5'd8);
    chk("lu stall_count hold", bus.stall_count, 16'd1);
    $display("load-use sequence: stall_count=%0d", bus.stall_count);

    // Backpressure for 3 cycles, then back-to-back replacement.
    do_reset();
    bus.out_ready = 1'b1;
    set_in(1'b1, 5'd1, 32'h11, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 3'b001, 5'd2, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 5'd3, 32'h22, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 3'b110, 5'd9, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("bp%0d out_valid", k), bus.out_valid, 1'b1);
      chk($sformatf("bp%0d in_ready", k), bus.in_ready, 1'b0);
      chk($sformatf("bp%0d alu_a", k), bus.alu_a, 32'h11);
      chk($sformatf("bp%0d alu_cont", k), bus.alu_cont, 3'b001);
      tick();
    end
    bus.out_ready = 1'b1;
    settle();
    chk("bp release in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    settle();
    chk("b2b out_valid", bus.out_valid, 1'b1);
    chk("b2b alu_a", bus.alu_a, 32'h22);
    chk("b2b alu_cont", bus.alu_cont, 3'b110);
    $display("backpressure sequence: alu_a=0x%0h", bus.alu_a);

    // Flush while FULL with an incoming transfer: both lost.
    set_in(1'b1, 5'd5, 32'h33, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 3'b000, 5'd10, 1'b1, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    settle();
    chk("flush out_valid", bus.out_valid, 1'b0);
    chk("flush alu_a kept", bus.alu_a, 32'h22);
    tick();
    settle();
    chk("flush out_valid later", bus.out_valid, 1'b0);

    // Asynchronous reset mid-stream.
    set_in(1'b1, 5'd1, 32'h44, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 3'b010, 5'd3, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("pre-rst out_valid", bus.out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async rst out_valid", bus.out_valid, 1'b0);
    chk("async rst in_ready", bus.in_ready, 1'b0);
    chk("async rst alu_a", bus.alu_a, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    $display("flush/reset sequence done");

    // Forwarding priority and the zero register.
`ifdef ALU_FWD_EN
    fwd_exp = 32'h10;
`else
    fwd_exp = 32'h99;
`endif
    do_reset();
    set_in(1'b1, 5'd3, 32'h99, 5'd3, 32'h77, 1'b1, 32'd0, 1'b0, 3'b010, 5'd1, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    bus.exm_regwrite = 1'b1; bus.exm_rd = 5'd3; bus.exm_result = 32'h10;
    bus.wb_regwrite  = 1'b1; bus.wb_rd  = 5'd3; bus.wb_result  = 32'h20;
    settle();
    chk("fwd exm alu_a", bus.alu_a, fwd_exp);
    chk("fwd exm alu_b", bus.alu_b, (fwd_exp == 32'h10) ? 32'h10 : 32'h77);
    bus.exm_regwrite = 1'b0;
    settle();
`ifdef ALU_FWD_EN
    fwd_exp = 32'h20;
`endif
    chk("fwd wb alu_a", bus.alu_a, fwd_exp);
    chk("fwd wb store_data", bus.out_store_data, (fwd_exp == 32'h20) ? 32'h20 : 32'h77);
    bus.wb_regwrite = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b1, 5'd0, 32'h55, 5'd0, 32'h66, 1'b1, 32'd0, 1'b0, 3'b010, 5'd1, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.exm_regwrite = 1'b1; bus.exm_rd = 5'd0; bus.exm_result = 32'hAA;
    bus.wb_regwrite  = 1'b1; bus.wb_rd  = 5'd0; bus.wb_result  = 32'hBB;
    settle();
    chk("r0 alu_a", bus.alu_a, 32'h55);
    chk("r0 alu_b", bus.alu_b, 32'h66);
    $display("forwarding sequence done");

    // Pending EX/MEM writer stall.
    do_reset();
    bus.out_ready = 1'b1;
    bus.exm_regwrite = 1'b1; bus.exm_rd = 5'd6;
    set_in(1'b1, 5'd6, 32'd1, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 3'b010, 5'd1, 1'b1, 1'b0);
`ifdef ALU_FWD_EN
    settle();
    chk("exm fwd no stall", bus.in_ready, 1'b1);
    tick();
`else
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("exm stall%0d in_ready", k), bus.in_ready, 1'b0);
      tick();
    end
    bus.exm_regwrite = 1'b0;
    settle();
    chk("exm cleared in_ready", bus.in_ready, 1'b1);
    chk("exm stall_count", bus.stall_count, 16'd2);
    tick();
`endif
    bus.in_valid = 1'b0;
    bus.exm_regwrite = 1'b0;
    settle();
    chk("exm issued out_valid", bus.out_valid, 1'b1);
    $display("exm stall sequence done");

    // Randomized run against the reference model.
    do_reset();
    m = '{default: '0};
    m_full = 1'b0;
    m_stall = 16'd0;
    ntx = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), $urandom, 1'($urandom), $urandom, 1'($urandom),
             3'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 3) == 0));
      bus.exm_regwrite = 1'($urandom);
      bus.exm_rd       = 5'($urandom_range(0, 7));
      bus.exm_result   = $urandom;
      bus.wb_regwrite  = 1'($urandom);
      bus.wb_rd        = 5'($urandom_range(0, 7));
      bus.wb_result    = $urandom;
      bus.flush        = ($urandom_range(0, 15) == 0);
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hz      = ref_hazard();
      exp_rdy = !hz && (!m_full || bus.out_ready);
      exp_b   = m.alusrc ? m.imm : ref_fwd(m.rt, m.rt_val);
      chk("rnd out_valid", bus.out_valid, m_full);
      chk("rnd in_ready", bus.in_ready, exp_rdy);
      chk("rnd alu_a", bus.alu_a, ref_fwd(m.rs, m.rs_val));
      chk("rnd alu_b", bus.alu_b, exp_b);
      chk("rnd store_data", bus.out_store_data, ref_fwd(m.rt, m.rt_val));
      chk("rnd alu_cont", bus.alu_cont, m.cont);
      chk("rnd out_rd", bus.out_rd, m.rd);
      chk("rnd out_regwrite", bus.out_regwrite, m.regwrite);
      chk("rnd out_memtoreg", bus.out_memtoreg, m.memtoreg);
      chk("rnd stall_count", bus.stall_count, m_stall);
      if (bus.in_valid && hz && !bus.flush && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (bus.flush) begin
        m_full = 1'b0;
      end else if (bus.in_valid && exp_rdy) begin
        m.rs = bus.in_rs; m.rt = bus.in_rt; m.rd = bus.in_rd;
        m.rs_val = bus.in_rs_val; m.rt_val = bus.in_rt_val; m.imm = bus.in_imm;
        m.alusrc = bus.in_alusrc; m.regwrite = bus.in_regwrite;
        m.memtoreg = bus.in_memtoreg; m.cont = bus.in_alucont;
        m_full = 1'b1;
        ntx++;
        $display("rnd txn %0d: rs=%0d rt=%0d rd=%0d cont=%0b", ntx, m.rs, m.rt, m.rd, m.cont);
      end else if (m_full && bus.out_ready) begin
        m_full = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
